qspi_flash_target: RTL and testbench
====================================

// Module: qspi_flash_target
// PURPOSE
//  Synthesizable quad-SPI flash responder: the target end of the CS/CLOCK/IO0-IO3 link driven by the spi
//  controller. Serves READ (0x03, single-bit) and QUAD OUTPUT FAST READ (0x6B) from an internal byte memory
//  preloaded via a side port. Used as an on-chip flash stand-in for boot/instruction-fetch bring-up.
//  Runs on ACLK and oversamples CLOCK/CS; no logic is clocked by CLOCK.
// PARAMETERS
//  ADDR_SIZE   24   width of the address shifted in after the command byte
//  MEM_DEPTH   256  bytes of internal memory (power of 2); address uses low $clog2(MEM_DEPTH) bits
//  DUMMY_CLKS  8    CLOCK cycles between last address bit and first data nibble for 0x6B
// PORTS
//  ACLK       in   1          system clock; must be >= 4x CLOCK frequency
//  ARESETn    in   1          asynchronous active-low reset
//  CS         in   1          SPI chip select, active low
//  CLOCK      in   1          SPI serial clock, mode 0 (idle low)
//  io_in      in   4          sampled IO3..IO0 pad inputs
//  io_out     out  4          IO3..IO0 pad output values
//  io_oe      out  4          per-pin output enable (1 = target drives)
//  load_en    in   1          write load_data to memory at load_addr this cycle
//  load_addr  in   $clog2(MEM_DEPTH)  preload address
//  load_data  in   8          preload byte
//  busy       out  1          1 while CS synchronized low
//  cmd_error  out  1          one-ACLK pulse on unsupported command byte
// BEHAVIOUR
//  Reset: io_out=0, io_oe=0, busy=0, cmd_error=0, FSM=IDLE, shift/bit counters=0; memory not cleared.
//  CS, CLOCK, io_in pass 2-flop synchronizers; rise/fall = edge of synchronized CLOCK (3rd flop compare).
//  Latency: response to any CLOCK edge or CS change within 3 ACLK cycles.
//  Sampling on CLOCK rise, driving on CLOCK fall (mode 0).
//  FSM: IDLE -> CMD on synchronized CS fall.
//   CMD: shift 8 bits MSB-first from IO0; after 8th rise: 0x03 -> ADDR, 0x6B -> ADDR, else pulse
//        cmd_error, -> IGNORE.
//   ADDR: shift ADDR_SIZE bits MSB-first from IO0; after last rise: 0x03 -> DATA1, 0x6B -> DUMMY.
//   DUMMY: count DUMMY_CLKS rises; on the fall after the last one drive first nibble, -> DATA4.
//   DATA1: each fall drives next bit on IO1 (io_oe=4'b0010), MSB first; first bit on fall after last
//          address rise. After 8 bits address+1.
//   DATA4: each fall drives next nibble on IO3..IO0 (io_oe=4'b1111), high nibble first; after 2 nibbles
//          address+1.
//   IGNORE: no drive, wait for CS high.
//  Address wraps modulo MEM_DEPTH (MEM_DEPTH-1 -> 0), upper address bits ignored.
//  Memory read is registered: next byte fetched when the current byte's first bit/nibble is
//  launched, so it is ready before it is needed at the ACLK:CLOCK >= 4 ratio.
//  CS high in any state (mid-command, mid-address, mid-data) -> IDLE, io_oe=0, counters cleared,
//  within 3 ACLK cycles; partial bytes discarded.
//  CLOCK edges while CS high are ignored.
//  load_en honoured only when busy=0; ignored while busy=1.
//  load_en in the same cycle as synchronized CS fall: write completes, busy rises next cycle.
//  cmd_error and io_oe never asserted while busy=0.
// TESTING
//  1 Preload mem[0x10..0x13]=A5,3C,F0,0F; 0x03 + addr 0x000010, 32 clocks
//    -> IO1 yields A5 3C F0 0F, io_oe=0010.
//  2 Preload mem[0x20]=0x9E,[0x21]=0x47; 0x6B + addr 0x000020 + 8 dummy, 4 clocks
//    -> nibbles 9,E,4,7, io_oe=1111.
//  3 MEM_DEPTH=256, 0x03 at addr 0x0000FF, 16 clocks -> mem[0xFF] then mem[0x00].
//    Addr 0xAB12FF returns the same bytes.
//  4 Command 0x9F -> cmd_error one pulse, io_oe stays 0 for the whole transfer, then IDLE.
//  5 CS raised after 12 address bits, then new 0x03 at 0x000010 -> io_oe=0 within 3 ACLK;
//    second read returns A5 correctly.
//  6 load_en while busy=1 -> memory unchanged. load_en with busy=0 -> next read returns new byte.
//    ARESETn low mid-DATA4 -> io_oe=0 immediately.

Source files
------------

// File: rtl/qspi_flash_target.sv
// Quad-SPI flash responder serving READ (0x03) and quad output read (0x6B).
// All logic runs on ACLK; CS, CLOCK and IO are oversampled.
module qspi_flash_target #(
   parameter int ADDR_SIZE  = 24,
   parameter int MEM_DEPTH  = 256,
   parameter int DUMMY_CLKS = 8
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   input  logic                         CS,
   input  logic                         CLOCK,
   input  logic [3:0]                   io_in,
   output logic [3:0]                   io_out,
   output logic [3:0]                   io_oe,
   input  logic                         load_en,
   input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
   input  logic [7:0]                   load_data,
   output logic                         busy,
   output logic                         cmd_error
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int CMAX =
      (ADDR_SIZE > DUMMY_CLKS) ? ADDR_SIZE : DUMMY_CLKS;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_SIZE - 1);
   localparam logic [CW-1:0] DUMMY_END = CW'(DUMMY_CLKS);
   localparam logic [CW-1:0] BIT_LAST  = CW'(7);
   localparam logic [CW-1:0] ONE       = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA1,
      DATA4,
      IGNORE
   } state_t;

   state_t          state;
   logic [2:0]      cs_sync;
   logic [2:0]      clk_sync;
   logic [3:0]      io_s1;
   logic [3:0]      io_s2;
   logic [CW-1:0]   bit_cnt;
   logic [6:0]      cmd_sr;
   logic [AW-1:0]   addr;
   logic            quad;
   logic [7:0]      sh_byte;
   logic [7:0]      rd_q;
   logic [7:0]      mem [MEM_DEPTH];

   logic            cs_hi;
   logic            cs_fall;
   logic            sck_rise;
   logic            sck_fall;
   logic            sdi;
   logic [7:0]      cmd_byte;
   logic            unused_io;

   assign cs_hi     = cs_sync[1];
   assign cs_fall   = cs_sync[2] & ~cs_sync[1];
   assign sck_rise  = clk_sync[1] & ~clk_sync[2];
   assign sck_fall  = ~clk_sync[1] & clk_sync[2];
   assign sdi       = io_s2[0];
   assign cmd_byte  = {cmd_sr, sdi};
   assign unused_io = ^io_s2[3:1];

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         cs_sync  <= 3'b111;
         clk_sync <= 3'b000;
         io_s1    <= 4'h0;
         io_s2    <= 4'h0;
      end else begin
         cs_sync  <= {cs_sync[1:0], CS};
         clk_sync <= {clk_sync[1:0], CLOCK};
         io_s1    <= io_in;
         io_s2    <= io_s1;
      end
   end

   // Registered read follows addr, so the next byte is
   // ready long before its first bit is launched.
   always_ff @(posedge ACLK) begin
      if (load_en && !busy)
         mem[load_addr] <= load_data;
      rd_q <= mem[addr];
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         cmd_sr    <= '0;
         addr      <= '0;
         quad      <= 1'b0;
         sh_byte   <= 8'h00;
         io_out    <= 4'h0;
         io_oe     <= 4'h0;
         busy      <= 1'b0;
         cmd_error <= 1'b0;
      end else begin
         busy      <= ~cs_hi;
         cmd_error <= 1'b0;
         if (cs_hi) begin
            state   <= IDLE;
            bit_cnt <= '0;
            io_out  <= 4'h0;
            io_oe   <= 4'h0;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state   <= CMD;
                     bit_cnt <= '0;
                  end
               end
               CMD: begin
                  if (sck_rise) begin
                     cmd_sr <= cmd_byte[6:0];
                     if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        unique case (1'b1)
                           (cmd_byte == 8'h03): begin
                              quad  <= 1'b0;
                              state <= ADDR;
                           end
                           (cmd_byte == 8'h6B): begin
                              quad  <= 1'b1;
                              state <= ADDR;
                           end
                           default: begin
                              cmd_error <= 1'b1;
                              state     <= IGNORE;
                           end
                        endcase
                     end else begin
                        bit_cnt <= bit_cnt + ONE;
                     end
                  end
               end
               ADDR: begin
                  // Upper address bits simply fall off the top.
                  if (sck_rise) begin
                     addr <= {addr[AW-2:0], sdi};
                     if (bit_cnt == ADDR_LAST) begin
                        bit_cnt <= '0;
                        state   <= quad ? DUMMY : DATA1;
                     end else begin
                        bit_cnt <= bit_cnt + ONE;
                     end
                  end
               end
               DUMMY: begin
                  if (sck_rise && bit_cnt != DUMMY_END) begin
                     bit_cnt <= bit_cnt + ONE;
                  end else if (sck_fall &&
                               bit_cnt == DUMMY_END) begin
                     io_out  <= rd_q[7:4];
                     io_oe   <= 4'hF;
                     sh_byte <= rd_q;
                     addr    <= addr + 1'b1;
                     bit_cnt <= ONE;
                     state   <= DATA4;
                  end
               end
               DATA1: begin
                  if (sck_fall) begin
                     io_oe <= 4'b0010;
                     if (bit_cnt == '0) begin
                        io_out  <= {2'b00, rd_q[7], 1'b0};
                        sh_byte <= {rd_q[6:0], 1'b0};
                        addr    <= addr + 1'b1;
                        bit_cnt <= ONE;
                     end else begin
                        io_out  <= {2'b00, sh_byte[7], 1'b0};
                        sh_byte <= {sh_byte[6:0], 1'b0};
                        bit_cnt <= (bit_cnt == BIT_LAST) ?
                                   '0 : bit_cnt + ONE;
                     end
                  end
               end
               DATA4: begin
                  if (sck_fall) begin
                     io_oe <= 4'hF;
                     if (bit_cnt == '0) begin
                        io_out  <= rd_q[7:4];
                        sh_byte <= rd_q;
                        addr    <= addr + 1'b1;
                        bit_cnt <= ONE;
                     end else begin
                        io_out  <= sh_byte[3:0];
                        bit_cnt <= '0;
                     end
                  end
               end
               IGNORE: begin
                  io_oe <= 4'h0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qspi_flash_target.sv
// Directed bench for qspi_flash_target: single and quad reads,
// wrap, bad command, CS abort, load gating and async reset.
module tb_qspi_flash_target;

   localparam int HALF = 40;

   logic       ACLK = 1'b0;
   logic       ARESETn = 1'b0;
   logic       CS = 1'b1;
   logic       CLOCK = 1'b0;
   logic [3:0] io_in = 4'h0;
   logic [3:0] io_out;
   logic [3:0] io_oe;
   logic       load_en = 1'b0;
   logic [7:0] load_addr = 8'h00;
   logic [7:0] load_data = 8'h00;
   logic       busy;
   logic       cmd_error;

   int ncmp = 0;
   int nerr = 0;
   int err_pulses = 0;
   int viol = 0;

   logic [3:0] smp;
   logic [3:0] smp_oe;
   logic [3:0] oe_acc;

   always #5 ACLK = ~ACLK;

   qspi_flash_target dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .CS        (CS),
      .CLOCK     (CLOCK),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oe     (io_oe),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .busy      (busy),
      .cmd_error (cmd_error)
   );

   always @(posedge ACLK) begin
      if (cmd_error === 1'b1)
         err_pulses <= err_pulses + 1;
      if ((io_oe !== 4'h0 || cmd_error !== 1'b0) && busy !== 1'b1)
         viol <= viol + 1;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic d0);
      io_in[0] = d0;
      #HALF;
      smp    = io_out;
      smp_oe = io_oe;
      oe_acc = oe_acc | io_oe;
      CLOCK  = 1'b1;
      #HALF;
      CLOCK  = 1'b0;
   endtask

   task automatic send8(input logic [7:0] b);
      for (int i = 7; i >= 0; i--)
         cyc(b[i]);
   endtask

   task automatic send_addr(input logic [23:0] a,
                            input int nbits);
      for (int i = 23; i >= 24 - nbits; i--)
         cyc(a[i]);
   endtask

   task automatic rd1(output logic [7:0] b,
                      output logic ok);
      ok = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         cyc(1'b0);
         b[i] = smp[1];
         if (smp_oe !== 4'b0010)
            ok = 1'b0;
      end
   endtask

   task automatic rd4(output logic [7:0] b,
                      output logic ok);
      ok = 1'b1;
      cyc(1'b0);
      b[7:4] = smp;
      if (smp_oe !== 4'hF)
         ok = 1'b0;
      cyc(1'b0);
      b[3:0] = smp;
      if (smp_oe !== 4'hF)
         ok = 1'b0;
   endtask

   task automatic cs_start();
      CS = 1'b0;
      #HALF;
   endtask

   task automatic cs_stop();
      CS    = 1'b1;
      io_in = 4'h0;
      #80;
   endtask

   task automatic load(input logic [7:0] a,
                       input logic [7:0] d);
      load_addr = a;
      load_data = d;
      load_en   = 1'b1;
      #10;
      load_en   = 1'b0;
   endtask

   task automatic read1_at(input logic [23:0] a,
                           output logic [7:0] b,
                           output logic ok);
      cs_start();
      send8(8'h03);
      send_addr(a, 24);
      rd1(b, ok);
      cs_stop();
   endtask

   logic [7:0] b;
   logic       ok;
   int         e0;

   initial begin
      #22;
      check("rst_io_oe", 32'(io_oe), 32'h0);
      check("rst_io_out", 32'(io_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_cmd_error", 32'(cmd_error), 32'h0);
      ARESETn = 1'b1;
      #40;

      load(8'h10, 8'hA5);
      load(8'h11, 8'h3C);
      load(8'h12, 8'hF0);
      load(8'h13, 8'h0F);
      cs_start();
      send8(8'h03);
      send_addr(24'h000010, 24);
      rd1(b, ok);
      check("rd1_b0", 32'(b), 32'hA5);
      check("rd1_oe0", 32'(ok), 32'h1);
      rd1(b, ok);
      check("rd1_b1", 32'(b), 32'h3C);
      rd1(b, ok);
      check("rd1_b2", 32'(b), 32'hF0);
      rd1(b, ok);
      check("rd1_b3", 32'(b), 32'h0F);
      check("rd1_oe3", 32'(ok), 32'h1);
      check("rd1_busy", 32'(busy), 32'h1);
      cs_stop();
      check("rd1_idle_busy", 32'(busy), 32'h0);
      check("rd1_idle_oe", 32'(io_oe), 32'h0);

      load(8'h20, 8'h9E);
      load(8'h21, 8'h47);
      cs_start();
      send8(8'h6B);
      send_addr(24'h000020, 24);
      for (int i = 0; i < 8; i++)
         cyc(1'b0);
      rd4(b, ok);
      check("rd4_b0", 32'(b), 32'h9E);
      check("rd4_oe0", 32'(ok), 32'h1);
      rd4(b, ok);
      check("rd4_b1", 32'(b), 32'h47);
      check("rd4_oe1", 32'(ok), 32'h1);
      cs_stop();

      load(8'hFF, 8'h5A);
      load(8'h00, 8'hC3);
      cs_start();
      send8(8'h03);
      send_addr(24'h0000FF, 24);
      rd1(b, ok);
      check("wrap_ff", 32'(b), 32'h5A);
      rd1(b, ok);
      check("wrap_00", 32'(b), 32'hC3);
      cs_stop();
      cs_start();
      send8(8'h03);
      send_addr(24'hAB12FF, 24);
      rd1(b, ok);
      check("hi_ff", 32'(b), 32'h5A);
      rd1(b, ok);
      check("hi_00", 32'(b), 32'hC3);
      cs_stop();

      e0 = err_pulses;
      oe_acc = 4'h0;
      cs_start();
      send8(8'h9F);
      for (int i = 0; i < 16; i++)
         cyc(1'b0);
      check("bad_pulses", 32'(err_pulses - e0), 32'd1);
      check("bad_oe", 32'(oe_acc), 32'h0);
      check("bad_busy", 32'(busy), 32'h1);
      cs_stop();
      check("bad_idle", 32'(busy), 32'h0);

      cs_start();
      send8(8'h03);
      send_addr(24'h000010, 12);
      CS = 1'b1;
      #30;
      check("ab_addr_oe", 32'(io_oe), 32'h0);
      check("ab_addr_busy", 32'(busy), 32'h0);
      #50;
      cs_start();
      send8(8'h03);
      send_addr(24'h000010, 24);
      rd1(b, ok);
      check("ab_pre_b", 32'(b), 32'hA5);
      cyc(1'b0);
      cyc(1'b0);
      cyc(1'b0);
      check("ab_mid_oe", 32'(io_oe), 32'h2);
      CS = 1'b1;
      #30;
      check("ab_data_oe", 32'(io_oe), 32'h0);
      check("ab_data_busy", 32'(busy), 32'h0);
      #50;
      read1_at(24'h000010, b, ok);
      check("ab_reread", 32'(b), 32'hA5);

      cs_start();
      check("ld_busy", 32'(busy), 32'h1);
      load(8'h10, 8'h11);
      cs_stop();
      read1_at(24'h000010, b, ok);
      check("ld_blocked", 32'(b), 32'hA5);
      load(8'h10, 8'h77);
      read1_at(24'h000010, b, ok);
      check("ld_written", 32'(b), 32'h77);

      cs_start();
      send8(8'h6B);
      send_addr(24'h000020, 24);
      for (int i = 0; i < 8; i++)
         cyc(1'b0);
      rd4(b, ok);
      check("rst4_b0", 32'(b), 32'h9E);
      cyc(1'b0);
      check("rst4_oe_on", 32'(io_oe), 32'hF);
      ARESETn = 1'b0;
      #1;
      check("rst4_oe_off", 32'(io_oe), 32'h0);
      check("rst4_busy", 32'(busy), 32'h0);
      CS = 1'b1;
      #29;
      ARESETn = 1'b1;
      #50;
      read1_at(24'h000020, b, ok);
      check("rst4_mem_kept", 32'(b), 32'h9E);

      check("busy_gating", 32'(viol), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

endmodule
